// File: rtl/sipo_rx.sv
// Serial-in parallel-out frame receiver: ss-framed, LSB-first, with a lead-in
// delay, single-word output buffer, valid/ack handshake and overrun/abort flags.
module sipo_rx #(
   parameter int WIDTH = 16,
   parameter int LEAD  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ss,
   input  logic             mosi,
   input  logic             ack,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam int LW = (LEAD < 1) ? 1 : $clog2(LEAD + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [LW-1:0] LEAD_LAST = LW'(LEAD - 1);
   // A lead of 0 or 1 edge is fully consumed by the IDLE exit edge itself.
   localparam logic          SKIP_LEAD = (LEAD <= 1) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    lead_cnt_q, lead_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             armed_q, armed_d;
   logic [WIDTH-1:0] next_word;

   // State, datapath and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lead_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         lead_cnt_q  <= lead_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         armed_q     <= armed_d;
      end
   end

   // Next-state, shift datapath, handshake and flag logic.
   always_comb begin
      state_d     = state_q;
      lead_cnt_d  = lead_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;
      // A frame may only start after ss has been seen high, so a reset taken
      // with ss held low cannot resume a stale frame.
      armed_d     = ss;
      next_word   = {mosi, shift_q[WIDTH-1:1]};

      if (valid_q && ack) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else begin
         valid_d   = valid_q;
         overrun_d = overrun_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (!ss && armed_q) begin
               shift_d = '0;
               if (SKIP_LEAD) begin
                  state_d   = ST_SHIFT;
                  bit_cnt_d = '0;
               end else begin
                  state_d    = ST_LEAD;
                  lead_cnt_d = LW'(1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LEAD: begin
            if (ss) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               lead_cnt_d  = '0;
            end else if (lead_cnt_q == LEAD_LAST) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
            end else begin
               lead_cnt_d = lead_cnt_q + LW'(1);
            end
         end
         ST_SHIFT: begin
            if (ss) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               bit_cnt_d   = '0;
            end else begin
               shift_d   = next_word;
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = ST_DONE;
                  // A simultaneous ack frees the buffer in time for the new word.
                  if (!valid_q || ack) begin
                     data_d  = next_word;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_DONE: begin
            if (ss) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_LEAD) || (state_d == ST_SHIFT);
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: an edge-counting frame model checked every cycle,
// plus literal checkpoints for the listed scenarios.
module tb_sipo_rx;

   localparam int W    = 16;
   localparam int LEAD = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         ss;
   logic         mosi;
   logic         ack;
   logic [W-1:0] data;
   logic         valid;
   logic         busy;
   logic         overrun;
   logic         frame_err;

   int total = 0;
   int bad   = 0;

   sipo_rx #(.WIDTH(W), .LEAD(LEAD)) dut (
      .clk(clk), .rst(rst), .ss(ss), .mosi(mosi), .ack(ack),
      .data(data), .valid(valid), .busy(busy),
      .overrun(overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Model: counts ss-low edges since the frame started; edges beyond the
   // lead-in carry bits 0..W-1 in order.
   logic [W-1:0] m_data, m_word;
   logic         m_valid, m_ovr, m_fe, m_busy;
   bit           m_armed, m_inframe, m_done;
   int           m_k;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_data = '0; m_word = '0; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      m_busy = 1'b0; m_armed = 1'b0; m_inframe = 1'b0; m_done = 1'b0; m_k = 0;
   endtask

   task automatic model_step(input logic s, input logic d, input logic a);
      logic old_valid;
      int   lead_eff;
      int   idx;
      lead_eff  = (LEAD < 1) ? 1 : LEAD;
      old_valid = m_valid;
      m_fe      = 1'b0;
      if (a && m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      if (s) begin
         if (m_inframe && !m_done) m_fe = 1'b1;
         m_inframe = 1'b0;
         m_done    = 1'b0;
         m_armed   = 1'b1;
      end else if (!m_inframe) begin
         if (m_armed) begin
            m_inframe = 1'b1;
            m_k       = 1;
            m_word    = '0;
            m_armed   = 1'b0;
         end
      end else if (!m_done) begin
         m_k++;
         if (m_k > lead_eff) begin
            idx = m_k - lead_eff - 1;
            m_word[idx] = d;
            if (idx == W - 1) begin
               m_done = 1'b1;
               if (!old_valid || a) begin
                  m_data  = m_word;
                  m_valid = 1'b1;
               end else begin
                  m_ovr = 1'b1;
               end
            end
         end
      end
      m_busy = m_inframe && !m_done;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step(ss, mosi, ack);
         #1;
         check("data",      data,          m_data);
         check("valid",     W'(valid),     W'(m_valid));
         check("busy",      W'(busy),      W'(m_busy));
         check("overrun",   W'(overrun),   W'(m_ovr));
         check("frame_err", W'(frame_err), W'(m_fe));
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ss = 1'b1; mosi = 1'b0;
      end
   endtask

   task automatic frame(input logic [W-1:0] w, input int nbits);
      for (int i = 0; i < LEAD; i++) begin
         @(negedge clk);
         ss = 1'b0; mosi = 1'b0;
      end
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         mosi = w[i];
      end
   endtask

   task automatic ack_pulse();
      @(negedge clk); ss = 1'b1; ack = 1'b1;
      @(negedge clk); ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ss = 1'b1; mosi = 1'b0; ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", W'(valid), W'(0));
      check("rst_data",  data,      16'h0000);
      rst = 1'b0;
      idle(2);

      // Basic frame and handshake
      frame(16'hA5C3, W);
      @(negedge clk);
      check("a5c3_data",  data,          16'hA5C3);
      check("a5c3_valid", W'(valid),     W'(1));
      check("a5c3_busy",  W'(busy),      W'(0));
      check("a5c3_fe",    W'(frame_err), W'(0));
      ack_pulse();
      check("ack_valid", W'(valid),   W'(0));
      check("ack_data",  data,        16'hA5C3);
      check("ack_ovr",   W'(overrun), W'(0));
      idle(2);

      // Overrun: second word dropped while the first is unacknowledged
      frame(16'h1234, W);
      idle(2);
      frame(16'hBEEF, W);
      @(negedge clk);
      check("ovr_data",  data,        16'h1234);
      check("ovr_flag",  W'(overrun), W'(1));
      check("ovr_valid", W'(valid),   W'(1));
      ack_pulse();
      check("ovr_clr_valid", W'(valid),   W'(0));
      check("ovr_clr_flag",  W'(overrun), W'(0));
      idle(2);

      // Abort after 7 bits
      frame(16'h007F, 7);
      @(negedge clk); ss = 1'b1;
      @(negedge clk);
      check("abort_fe",   W'(frame_err), W'(1));
      check("abort_busy", W'(busy),      W'(0));
      check("abort_data", data,          16'h1234);
      @(negedge clk);
      check("abort_fe_end", W'(frame_err), W'(0));
      frame(16'h0001, W);
      @(negedge clk);
      check("one_data", data, 16'h0001);
      ack_pulse();
      idle(2);

      // ss held low for 40 edges: only one word, tail ignored
      frame(16'hFFFF, W);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("ffff_data",  data,      16'hFFFF);
            check("ffff_valid", W'(valid), W'(1));
            ack = 1'b1;
         end else begin
            ack = 1'b0;
         end
         mosi = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("ffff_tail_valid", W'(valid), W'(0));
      check("ffff_tail_data",  data,      16'hFFFF);
      idle(2);

      // Reset in the middle of a frame with ss kept low afterwards
      frame(16'h01FF, 9);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("mid_rst_data",  data,          16'h0000);
      check("mid_rst_busy",  W'(busy),      W'(0));
      check("mid_rst_fe",    W'(frame_err), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mosi = 1'($urandom_range(0, 1));
      end
      check("post_rst_valid", W'(valid), W'(0));
      check("post_rst_busy",  W'(busy),  W'(0));
      idle(2);
      frame(16'h5A5A, W);
      @(negedge clk);
      check("resume_data",  data,      16'h5A5A);
      check("resume_valid", W'(valid), W'(1));
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
